// File: rtl/receive_ovs.sv
// Oversampling UART receiver: two-flop synchroniser, start-bit glitch rejection,
// 2-of-3 majority bit decisions, optional parity, one or two stop bits, break detect.
module receive_ovs #(
  parameter int BITS       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            tick,
  input  logic            rst,
  input  logic            en,
  input  logic            in,
  output logic [BITS-1:0] out,
  output logic            done,
  output logic            busy,
  output logic            error,
  output logic            parityErr,
  output logic            frameErr,
  output logic            breakDet
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(BITS + 1);

  localparam logic [CW-1:0] C_PRE = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_MID = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] C_DEC = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] I_LAST      = IW'(BITS - 1);
  localparam logic [IW-1:0] I_STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t          state;
  logic            sync1, rx;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            v0, v1;
  logic [BITS-1:0] shreg;
  logic            ones;      // running parity of received data ones
  logic            all_zero;  // every bit so far sampled 0 (break candidate)
  logic            pe_acc, fe_acc, brk_acc;
  logic            maj, fe_now, brk_now;

  // Both flops preset to 1 so reset never looks like a start edge.
  always_ff @(posedge tick or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= in;
      rx    <= sync1;
    end
  end

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    maj     = (v0 & v1) | (v0 & rx) | (v1 & rx);
    fe_now  = fe_acc | ~maj;
    brk_now = (idx == '0) ? (all_zero & ~maj) : brk_acc;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge tick or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      // NOTE: the shift register is reset too; it is tiny and a defined value keeps out clean.
      shreg     <= '0;
      ones      <= 1'b0;
      all_zero  <= 1'b1;
      pe_acc    <= 1'b0;
      fe_acc    <= 1'b0;
      brk_acc   <= 1'b0;
      out       <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      breakDet  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (en && !rx) begin
            state    <= S_START;
            cnt      <= CW'(1);
            busy     <= 1'b1;
            ones     <= 1'b0;
            all_zero <= 1'b1;
            pe_acc   <= 1'b0;
            fe_acc   <= 1'b0;
            brk_acc  <= 1'b0;
          end
        end

        S_START: begin
          if (cnt == C_MID && rx) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == C_END) begin
            state <= S_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA, S_PARITY, S_STOP: begin
          cnt <= (cnt == C_END) ? '0 : cnt + 1'b1;
          if (cnt == C_PRE) v0 <= rx;
          if (cnt == C_MID) v1 <= rx;

          if (cnt == C_DEC) begin
            if (state == S_DATA) begin
              shreg    <= {maj, shreg[BITS-1:1]};
              ones     <= ones ^ maj;
              all_zero <= all_zero & ~maj;
            end else if (state == S_PARITY) begin
              all_zero <= all_zero & ~maj;
              pe_acc   <= (PARITY == 1) ? ~(ones ^ maj) : (ones ^ maj);
            end else if (idx == I_STOP_LAST) begin
              out       <= shreg;
              parityErr <= pe_acc;
              frameErr  <= fe_now;
              breakDet  <= brk_now;
              error     <= pe_acc | fe_now;
              done      <= 1'b1;
              busy      <= 1'b0;
              cnt       <= '0;
              idx       <= '0;
              state     <= fe_now ? S_WAIT_HIGH : S_IDLE;
            end else begin
              fe_acc  <= fe_now;
              brk_acc <= brk_now;
            end
          end

          if (cnt == C_END) begin
            if (state == S_DATA) begin
              if (idx == I_LAST) begin
                idx   <= '0;
                state <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                idx <= idx + 1'b1;
              end
            end else if (state == S_PARITY) begin
              state <= S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        S_WAIT_HIGH: begin
          if (rx) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receive_ovs.sv
// Bench for receive_ovs: even-parity/one-stop instance (a) and no-parity/two-stop instance (b),
// directed and random frames checked against a frame-level reference model.
module tb_receive_ovs;

  localparam int OVS = 16;

  logic       tick = 1'b0;
  logic       rst, en, in_a, in_b;
  logic [7:0] out_a, out_b;
  logic       done_a, busy_a, error_a, pe_a, fe_a, brk_a;
  logic       done_b, busy_b, error_b, pe_b, fe_b, brk_b;

  int tests = 0;
  int fails = 0;

  int dcnt_a = 0, bcnt_a = 0, dcnt_b = 0;
  logic [7:0] c_out_a, c_out_b;
  logic       c_pe_a, c_fe_a, c_brk_a, c_err_a;
  logic       c_pe_b, c_fe_b, c_brk_b, c_err_b;

  logic [7:0] last_o;
  logic       last_pe, last_fe, last_brk;

  always #5 tick = ~tick;

  receive_ovs #(.BITS(8), .OVERSAMPLE(OVS), .PARITY(2), .STOP_BITS(1)) dut_a (
    .tick(tick), .rst(rst), .en(en), .in(in_a), .out(out_a), .done(done_a),
    .busy(busy_a), .error(error_a), .parityErr(pe_a), .frameErr(fe_a), .breakDet(brk_a)
  );

  receive_ovs #(.BITS(8), .OVERSAMPLE(OVS), .PARITY(0), .STOP_BITS(2)) dut_b (
    .tick(tick), .rst(rst), .en(en), .in(in_b), .out(out_b), .done(done_b),
    .busy(busy_b), .error(error_b), .parityErr(pe_b), .frameErr(fe_b), .breakDet(brk_b)
  );

  // Frame monitor: counts done pulses and busy cycles, captures outputs at each done.
  always @(negedge tick) begin
    if (done_a) begin
      dcnt_a++;
      c_out_a = out_a; c_pe_a = pe_a; c_fe_a = fe_a; c_brk_a = brk_a; c_err_a = error_a;
    end
    if (busy_a) bcnt_a++;
    if (done_b) begin
      dcnt_b++;
      c_out_b = out_b; c_pe_b = pe_b; c_fe_b = fe_b; c_brk_b = brk_b; c_err_b = error_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic b);
    in_a = b;
    repeat (OVS) @(negedge tick);
  endtask

  task automatic drive_b(input logic b);
    in_b = b;
    repeat (OVS) @(negedge tick);
  endtask

  task automatic send_a(input logic [7:0] d, input logic pb, input logic sb, input logic drop_en);
    drive_a(1'b0);
    if (drop_en) en = 1'b0;
    for (int i = 0; i < 8; i++) drive_a(d[i]);
    drive_a(pb);
    drive_a(sb);
    in_a = 1'b1;
    en   = 1'b1;
    repeat (OVS) @(negedge tick);
  endtask

  task automatic send_b(input logic [7:0] d, input logic s0, input logic s1);
    drive_b(1'b0);
    for (int i = 0; i < 8; i++) drive_b(d[i]);
    drive_b(s0);
    drive_b(s1);
    in_b = 1'b1;
    repeat (OVS) @(negedge tick);
  endtask

  // Reference model: even parity error when data+parity holds an odd number of ones;
  // break when data, parity and first stop all read 0.
  task automatic expect_a(input string tag, input int d0, input logic [7:0] d,
                          input logic pb, input logic sb);
    logic epe, efe, ebrk;
    epe  = (($countones(d) + int'(pb)) % 2) != 0;
    efe  = (sb == 1'b0);
    ebrk = (d == 8'h00) && (pb == 1'b0) && (sb == 1'b0);
    check({tag, " done_count"}, dcnt_a - d0, 1);
    check({tag, " out"}, c_out_a, d);
    check({tag, " parityErr"}, c_pe_a, epe);
    check({tag, " frameErr"}, c_fe_a, efe);
    check({tag, " breakDet"}, c_brk_a, ebrk);
    check({tag, " error"}, c_err_a, epe | efe);
    check({tag, " out_hold"}, out_a, d);
    last_o = d; last_pe = epe; last_fe = efe; last_brk = ebrk;
  endtask

  task automatic expect_b(input string tag, input int d0, input logic [7:0] d,
                          input logic s0, input logic s1);
    logic efe, ebrk;
    efe  = (s0 == 1'b0) || (s1 == 1'b0);
    ebrk = (d == 8'h00) && (s0 == 1'b0);
    check({tag, " done_count"}, dcnt_b - d0, 1);
    check({tag, " out"}, c_out_b, d);
    check({tag, " parityErr"}, c_pe_b, 1'b0);
    check({tag, " frameErr"}, c_fe_b, efe);
    check({tag, " breakDet"}, c_brk_b, ebrk);
    check({tag, " error"}, c_err_b, efe);
  endtask

  initial begin
    int d0, b0;
    logic [7:0] d;
    logic pb, sb, s0, s1, de;

    rst = 1'b1; en = 1'b0; in_a = 1'b1; in_b = 1'b1;
    repeat (3) @(negedge tick);
    check("reset out_a", out_a, 8'h00);
    check("reset done_a", done_a, 1'b0);
    check("reset busy_a", busy_a, 1'b0);
    check("reset flags_a", {error_a, pe_a, fe_a, brk_a}, 4'b0000);
    check("reset out_b", out_b, 8'h00);
    check("reset flags_b", {busy_b, error_b, pe_b, fe_b, brk_b}, 5'b00000);
    rst = 1'b0;
    last_o = 8'h00; last_pe = 1'b0; last_fe = 1'b0; last_brk = 1'b0;
    repeat (4) @(negedge tick);

    // en low: a low pulse must not start a frame
    d0 = dcnt_a; b0 = bcnt_a;
    drive_a(1'b0);
    drive_a(1'b1);
    check("en_gate done_count", dcnt_a - d0, 0);
    check("en_gate busy_cycles", bcnt_a - b0, 0);
    en = 1'b1;
    repeat (4) @(negedge tick);

    d0 = dcnt_a; send_a(8'hA5, 1'b0, 1'b1, 1'b0); expect_a("good_A5", d0, 8'hA5, 1'b0, 1'b1);
    d0 = dcnt_a; send_a(8'hA5, 1'b1, 1'b1, 1'b0); expect_a("bad_parity_A5", d0, 8'hA5, 1'b1, 1'b1);
    d0 = dcnt_a; send_a(8'h3C, 1'b0, 1'b0, 1'b0); expect_a("stop0_3C", d0, 8'h3C, 1'b0, 1'b0);
    check("stop0_3C busy_after", busy_a, 1'b0);
    d0 = dcnt_a; send_a(8'h5E, 1'b1, 1'b1, 1'b0); expect_a("after_wait_high", d0, 8'h5E, 1'b1, 1'b1);

    // 4-tick glitch: rejected at the start-bit midpoint
    d0 = dcnt_a; b0 = bcnt_a;
    in_a = 1'b0;
    repeat (4) @(negedge tick);
    in_a = 1'b1;
    repeat (30) @(negedge tick);
    check("glitch done_count", dcnt_a - d0, 0);
    check("glitch busy_bounded", (bcnt_a - b0 >= 1) && (bcnt_a - b0 <= 8), 1'b1);
    check("glitch out", out_a, last_o);
    check("glitch flags", {pe_a, fe_a, brk_a, error_a}, {last_pe, last_fe, last_brk, last_pe | last_fe});

    // break: line low for 12 bit times, then high
    d0 = dcnt_a;
    in_a = 1'b0;
    repeat (12 * OVS) @(negedge tick);
    check("break busy_in_wait", busy_a, 1'b0);
    in_a = 1'b1;
    repeat (2 * OVS) @(negedge tick);
    expect_a("break", d0, 8'h00, 1'b0, 1'b0);
    d0 = dcnt_a; send_a(8'h96, 1'b0, 1'b1, 1'b0); expect_a("after_break", d0, 8'h96, 1'b0, 1'b1);

    // en dropped after the start bit must not abort the frame
    d0 = dcnt_a; send_a(8'h71, 1'b0, 1'b1, 1'b1); expect_a("en_drop", d0, 8'h71, 1'b0, 1'b1);

    // reset during data bit 3 discards the frame
    d0 = dcnt_a;
    drive_a(1'b0);
    for (int i = 0; i < 3; i++) drive_a(1'b1);
    in_a = 1'b1;
    repeat (OVS / 2) @(negedge tick);
    rst = 1'b1;
    #1;
    check("abort busy_async", busy_a, 1'b0);
    repeat (2) @(negedge tick);
    rst = 1'b0;
    repeat (2 * OVS) @(negedge tick);
    check("abort done_count", dcnt_a - d0, 0);
    check("abort out_cleared", out_a, 8'h00);
    last_o = 8'h00; last_pe = 1'b0; last_fe = 1'b0; last_brk = 1'b0;
    d0 = dcnt_a; send_a(8'h81, 1'b0, 1'b1, 1'b0); expect_a("after_abort_81", d0, 8'h81, 1'b0, 1'b1);

    // random frames on the parity instance
    for (int k = 0; k < 8; k++) begin
      d  = 8'($urandom);
      if (k == 3) d = 8'h00;
      pb = 1'(($countones(d) % 2) != 0) ^ 1'($urandom_range(0, 3) == 0);
      sb = 1'($urandom_range(0, 3) != 0);
      de = 1'($urandom_range(0, 1));
      d0 = dcnt_a;
      send_a(d, pb, sb, de);
      expect_a($sformatf("rand_a%0d", k), d0, d, pb, sb);
    end

    // two-stop no-parity instance
    d0 = dcnt_b; send_b(8'h5A, 1'b1, 1'b1); expect_b("b_good", d0, 8'h5A, 1'b1, 1'b1);
    d0 = dcnt_b; send_b(8'h5A, 1'b1, 1'b0); expect_b("b_stop2_low", d0, 8'h5A, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      d  = 8'($urandom);
      s0 = 1'($urandom_range(0, 2) != 0);
      s1 = 1'($urandom_range(0, 2) != 0);
      d0 = dcnt_b;
      send_b(d, s0, s1);
      expect_b($sformatf("rand_b%0d", k), d0, d, s0, s1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
